// File: rtl/store_half_rmw.sv
// store_half_rmw
// Store path for byte, half-word and word stores into a 32-bit, word-addressed
// data memory. Sub-word stores read the target word, merge the new lane(s)
// into it and write the whole word back. Word stores skip the read. Bad sizes
// and misaligned addresses finish immediately with err and touch no memory.
// The pipeline is held through busy until the store has completed.

module store_half_rmw #(
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [1:0]        SIG_StoreSize,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata
);

    // Store size encodings
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // The wait counter runs from MEM_LAT-1 down to zero, so one WAIT cycle
    // is spent per cycle of read latency.
    localparam int                CNT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Registered state, request latches and outputs
    state_t              state_q,     state_d;
    logic [1:0]          size_q,      size_d;
    logic [1:0]          lane_q,      lane_d;
    logic [31:0]         wdata_q,     wdata_d;
    logic [CNT_W-1:0]    wait_cnt_q,  wait_cnt_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic                err_q,       err_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic                mem_re_q,    mem_re_d;
    logic                mem_we_q,    mem_we_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;

    // Address bits above the word index wrap away; they are deliberately
    // not part of the memory address.
    logic unused_addr_s;
    assign unused_addr_s = ^addr[31:ADDR_W+2];

    // Returns 1 when the size/offset pair cannot be stored in one word
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offs);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offs[0];
            SZ_WORD: bad = (offs != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Inserts the truncated store data into the selected lane(s) of the
    // word read back from memory (little-endian lane numbering).
    function automatic logic [31:0] merge_word(
        input logic [1:0]  size,
        input logic [1:0]  offs,
        input logic [31:0] rword,
        input logic [31:0] sdata
    );
        logic [31:0] res;
        case (size)
            SZ_BYTE: begin
                case (offs)
                    2'b00:   res = {rword[31:8],  sdata[7:0]};
                    2'b01:   res = {rword[31:16], sdata[7:0], rword[7:0]};
                    2'b10:   res = {rword[31:24], sdata[7:0], rword[15:0]};
                    2'b11:   res = {sdata[7:0],   rword[23:0]};
                    default: res = rword;
                endcase
            end
            SZ_HALF: begin
                if (offs[1]) begin
                    res = {sdata[15:0], rword[15:0]};
                end else begin
                    res = {rword[31:16], sdata[15:0]};
                end
            end
            default: res = sdata;
        endcase
        return res;
    endfunction

    // Next-state and next-output decode for the store sequencer
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        wait_cnt_d  = wait_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    size_d     = SIG_StoreSize;
                    lane_d     = addr[1:0];
                    wdata_d    = wdata;
                    mem_addr_d = addr[ADDR_W+1:2];
                    busy_d     = 1'b1;
                    if (is_misaligned(SIG_StoreSize, addr[1:0])) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (SIG_StoreSize == SZ_WORD) begin
                        // Full word: nothing to preserve, write directly
                        state_d     = ST_WRITE;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = wdata;
                    end else begin
                        state_d  = ST_READ;
                        mem_re_d = 1'b1;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_READ: begin
                state_d    = ST_WAIT;
                wait_cnt_d = WAIT_INIT;
            end
            ST_WAIT: begin
                if (wait_cnt_q == CNT_ZERO) begin
                    // Read data is valid now: capture and merge in one step
                    state_d     = ST_WRITE;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merge_word(size_q, lane_q, mem_rdata, wdata_q);
                end else begin
                    wait_cnt_d = wait_cnt_q - CNT_ONE;
                end
            end
            ST_WRITE: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any store in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            size_q      <= 2'b00;
            lane_q      <= 2'b00;
            wdata_q     <= 32'h0000_0000;
            wait_cnt_q  <= CNT_ZERO;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            wait_cnt_q  <= wait_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_store_half_rmw.sv
// Bench for store_half_rmw: two instances (read latency 1 and 3) run the same
// stores in lockstep, each against its own word memory model. Expected
// records are queued when a store is issued and compared against what the
// monitor records at each done pulse.

module tb_store_half_rmw;

    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [1:0]    busy_w, done_w, err_w, re_w, we_w;
    logic [AW-1:0] maddr_w  [2];
    logic [31:0]   rdata_w  [2];
    logic [31:0]   mwdata_w [2];

    store_half_rmw #(.ADDR_W(AW), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req), .SIG_StoreSize(sz),
        .addr(addr), .wdata(wdata), .busy(busy_w[0]), .done(done_w[0]),
        .err(err_w[0]), .mem_addr(maddr_w[0]), .mem_re(re_w[0]),
        .mem_rdata(rdata_w[0]), .mem_we(we_w[0]), .mem_wdata(mwdata_w[0])
    );

    store_half_rmw #(.ADDR_W(AW), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .req(req), .SIG_StoreSize(sz),
        .addr(addr), .wdata(wdata), .busy(busy_w[1]), .done(done_w[1]),
        .err(err_w[1]), .mem_addr(maddr_w[1]), .mem_re(re_w[1]),
        .mem_rdata(rdata_w[1]), .mem_we(we_w[1]), .mem_wdata(mwdata_w[1])
    );

    // Word memories; the bench preloads a word through init_*
    logic [31:0]   mem_m [2][1024];
    logic          init_en;
    logic [AW-1:0] init_idx;
    logic [31:0]   init_data;

    // Synchronous memory model: registered read data, write on mem_we
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (init_en) begin
                mem_m[k][init_idx] <= init_data;
            end else if (we_w[k]) begin
                mem_m[k][maddr_w[k]] <= mwdata_w[k];
            end
            if (re_w[k]) begin
                rdata_w[k] <= mem_m[k][maddr_w[k]];
            end
        end
    end

    typedef struct {
        logic          err;
        logic [31:0]   wdata;
        logic [31:0]   memv;
        logic [AW-1:0] re_addr;
        logic [AW-1:0] we_addr;
        int            re_cyc;
        int            we_cyc;
        int            done_cyc;
        int            re_n;
        int            we_n;
        int            overlap;
    } rec_t;

    rec_t exp_q0[$], exp_q1[$], obs_q0[$], obs_q1[$];

    int total = 0;
    int bad   = 0;

    function automatic rec_t blank_rec();
        rec_t r;
        r.err = 1'b0; r.wdata = 32'h0; r.memv = 32'h0;
        r.re_addr = '0; r.we_addr = '0;
        r.re_cyc = 0; r.we_cyc = 0; r.done_cyc = 0;
        r.re_n = 0; r.we_n = 0; r.overlap = 0;
        return r;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference behaviour: masks and replicated data, latency per read latency
    function automatic rec_t model(input logic [1:0] s, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] init, input int lat);
        rec_t r;
        logic [31:0] mask;
        logic [31:0] rep;
        logic misal;
        r = blank_rec();
        misal = (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
        r.re_addr = a[AW+1:2];
        r.we_addr = a[AW+1:2];
        if (misal) begin
            r.err = 1'b1; r.done_cyc = 1; r.memv = init;
        end else if (s == 2'b10) begin
            r.we_n = 1; r.we_cyc = 1; r.done_cyc = 2; r.wdata = wd; r.memv = wd;
        end else begin
            if (s == 2'b00) begin
                mask = 32'h0000_00FF << (8 * a[1:0]);
                rep  = {4{wd[7:0]}};
            end else begin
                mask = a[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                rep  = {2{wd[15:0]}};
            end
            r.re_n = 1; r.re_cyc = 1; r.we_n = 1; r.we_cyc = 2 + lat;
            r.done_cyc = 3 + lat;
            r.wdata = (init & ~mask) | (rep & mask);
            r.memv  = r.wdata;
        end
        return r;
    endfunction

    // Monitor: cycle count since accept and memory activity, recorded at done
    rec_t cur [2];
    int   cnt [2];
    initial begin
        for (int k = 0; k < 2; k++) begin
            cur[k] = blank_rec();
            cnt[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (reset !== 1'b0 || busy_w[k] !== 1'b1) begin
                    cnt[k] = 0;
                    cur[k] = blank_rec();
                end else begin
                    cnt[k]++;
                    if (re_w[k]) begin
                        cur[k].re_n++; cur[k].re_cyc = cnt[k]; cur[k].re_addr = maddr_w[k];
                    end
                    if (we_w[k]) begin
                        cur[k].we_n++; cur[k].we_cyc = cnt[k]; cur[k].we_addr = maddr_w[k];
                        cur[k].wdata = mwdata_w[k];
                    end
                    if (re_w[k] && we_w[k]) cur[k].overlap++;
                    if (done_w[k]) begin
                        cur[k].err = err_w[k];
                        cur[k].done_cyc = cnt[k];
                        if (k == 0) obs_q0.push_back(cur[k]);
                        else        obs_q1.push_back(cur[k]);
                        cur[k] = blank_rec();
                    end
                end
            end
        end
    end

    task automatic start_store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] init, input bit expect_it);
        @(negedge clk);
        init_en = 1'b1; init_idx = a[AW+1:2]; init_data = init;
        @(negedge clk);
        init_en = 1'b0;
        if (expect_it) begin
            exp_q0.push_back(model(s, a, wd, init, 1));
            exp_q1.push_back(model(s, a, wd, init, 3));
        end
        req = 1'b1; sz = s; addr = a; wdata = wd;
        @(negedge clk);
        // Scramble inputs after accept: the DUT must use its latched copy
        req = 1'b0; sz = ~s; addr = ~a; wdata = ~wd;
    endtask

    task automatic compare_rec(input string p, input int k, input rec_t e, input rec_t o);
        check_value({p, " err"},      32'(o.err),      32'(e.err));
        check_value({p, " done_cyc"}, 32'(o.done_cyc), 32'(e.done_cyc));
        check_value({p, " re_n"},     32'(o.re_n),     32'(e.re_n));
        check_value({p, " we_n"},     32'(o.we_n),     32'(e.we_n));
        check_value({p, " overlap"},  32'(o.overlap),  32'd0);
        if (e.re_n != 0) begin
            check_value({p, " re_cyc"},  32'(o.re_cyc),  32'(e.re_cyc));
            check_value({p, " re_addr"}, 32'(o.re_addr), 32'(e.re_addr));
        end
        if (e.we_n != 0) begin
            check_value({p, " we_cyc"},  32'(o.we_cyc),  32'(e.we_cyc));
            check_value({p, " we_addr"}, 32'(o.we_addr), 32'(e.we_addr));
            check_value({p, " wdata"},   o.wdata,        e.wdata);
        end
        check_value({p, " mem"}, mem_m[k][e.we_addr], e.memv);
    endtask

    task automatic finish_store(input string name);
        int   n;
        rec_t e;
        rec_t o;
        n = 0;
        while ((obs_q0.size() < exp_q0.size() || obs_q1.size() < exp_q1.size()) && n < 40) begin
            @(posedge clk);
            n++;
        end
        check_value({name, " timeout"}, 32'(n >= 40), 32'd0);
        while (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            if (obs_q0.size() > 0) begin
                o = obs_q0.pop_front();
                compare_rec({name, " L1"}, 0, e, o);
            end else begin
                check_value({name, " L1 missing done"}, 32'd0, 32'd1);
            end
        end
        while (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            if (obs_q1.size() > 0) begin
                o = obs_q1.pop_front();
                compare_rec({name, " L3"}, 1, e, o);
            end else begin
                check_value({name, " L3 missing done"}, 32'd0, 32'd1);
            end
        end
        check_value({name, " extra done"}, 32'(obs_q0.size() + obs_q1.size()), 32'd0);
        obs_q0.delete();
        obs_q1.delete();
        @(negedge clk);
        check_value({name, " busy after"}, 32'(busy_w), 32'd0);
    endtask

    task automatic check_zero_outs(input string name);
        for (int k = 0; k < 2; k++) begin
            check_value({name, " busy"},      32'(busy_w[k]),  32'd0);
            check_value({name, " done"},      32'(done_w[k]),  32'd0);
            check_value({name, " err"},       32'(err_w[k]),   32'd0);
            check_value({name, " mem_re"},    32'(re_w[k]),    32'd0);
            check_value({name, " mem_we"},    32'(we_w[k]),    32'd0);
            check_value({name, " mem_addr"},  32'(maddr_w[k]), 32'd0);
            check_value({name, " mem_wdata"}, mwdata_w[k],     32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  rs;
        logic [31:0] ra;
        reset = 1'b1; req = 1'b0; sz = 2'b00; addr = 32'h0; wdata = 32'h0;
        init_en = 1'b0; init_idx = '0; init_data = 32'h0;
        repeat (3) @(negedge clk);
        check_zero_outs("reset");
        reset = 1'b0;

        start_store(2'b01, 32'h0000_0008, 32'h1234_3F3F, 32'hAABB_CCDD, 1'b1);
        finish_store("half lo");
        start_store(2'b01, 32'h0000_000A, 32'h1234_3F3F, 32'hAABB_CCDD, 1'b1);
        finish_store("half hi");
        start_store(2'b00, 32'h0000_0007, 32'h0000_00FF, 32'h1122_3344, 1'b1);
        finish_store("byte 3");
        start_store(2'b00, 32'h0000_0010, 32'hABCD_EF5A, 32'h1122_3344, 1'b1);
        finish_store("byte 0");
        start_store(2'b00, 32'h0000_0015, 32'h0000_00C3, 32'h8877_6655, 1'b1);
        finish_store("byte 1");
        start_store(2'b10, 32'h0000_0004, 32'hFFFF_FFFF, 32'h0BAD_F00D, 1'b1);
        finish_store("word");
        start_store(2'b01, 32'h0000_0003, 32'h0000_BEEF, 32'h5555_AAAA, 1'b1);
        finish_store("half misal");
        start_store(2'b11, 32'h0000_0000, 32'h0000_BEEF, 32'h5555_AAAA, 1'b1);
        finish_store("size 11");
        start_store(2'b10, 32'h0000_0022, 32'hCAFE_BABE, 32'h1357_9BDF, 1'b1);
        finish_store("word misal");
        start_store(2'b01, 32'hFFFF_F012, 32'h0000_7E7E, 32'hDEAD_BEEF, 1'b1);
        finish_store("addr wrap");

        for (int i = 0; i < 8; i++) begin
            rs = 2'($urandom_range(0, 3));
            ra = $urandom;
            start_store(rs, ra, $urandom, $urandom, 1'b1);
            finish_store($sformatf("rand%0d", i));
        end

        // Reset during WAIT: everything clears at once, no write happens
        start_store(2'b01, 32'h0000_0030, 32'h5566_7788, 32'h0102_0304, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_zero_outs("rst wait");
        repeat (3) begin
            @(negedge clk);
            check_value("rst we", 32'(we_w), 32'd0);
        end
        reset = 1'b0;
        check_value("rst mem L1", mem_m[0][10'd12], 32'h0102_0304);
        check_value("rst mem L3", mem_m[1][10'd12], 32'h0102_0304);
        start_store(2'b01, 32'h0000_0032, 32'h0000_A5A5, 32'h0102_0304, 1'b1);
        finish_store("after rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_half_rmw.md
Name: store_half_rmw

Overview:
- Store-side counterpart to the load-path half-word sign/zero extender.
- Takes a 32-bit register value from the MEM stage and truncates it to a byte or half-word.
- Inserts the truncated value into the correct lane of a 32-bit word-addressed data memory using a read-modify-write sequence.
- Stalls the pipeline through `busy` until the write completes.

Parameters:
- ADDR_W, 10, data-memory word-address width.
- MEM_LAT, 1, memory read latency in cycles (≥1). This is the number of WAIT cycles before `mem_rdata` is captured.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  store request. Sampled only in IDLE.
- SIG_StoreSize  input  2  00 byte, 01 half-word, 10 word, 11 reserved.
- addr  input  32  byte address.
- wdata  input  32  register value to store. Byte uses [7:0]; half-word uses [15:0].
- busy  output  1  pipeline stall. High in every non-IDLE state.
- done  output  1  one-cycle completion pulse.
- err  output  1  misaligned or reserved-size flag. Valid only while `done`=1.
- mem_addr  output  ADDR_W  word address, equal to latched addr[ADDR_W+1:2].
- mem_re  output  1  memory read enable.
- mem_rdata  input  32  memory read data.
- mem_we  output  1  memory write enable.
- mem_wdata  output  32  merged word to write.

Behaviour:
- Reset (async): state=IDLE. `busy`, `done`, `err`, `mem_re`, `mem_we` = 0. `mem_addr`, `mem_wdata` = 0. All latches cleared.
- Reset mid-operation: `mem_we` drops immediately, no partial write, `done` is not pulsed.
- Accept: on a clk edge in IDLE with `req`=1, latch `addr`, `wdata` and `SIG_StoreSize`. `req` is ignored in all other states.
- Lane rules (little-endian):
  - Byte lane = addr[1:0].
  - Half-word: addr[1]=0 selects bits [15:0]; addr[1]=1 selects bits [31:16].
  - Unselected lanes are copied from the captured read word.
- Misaligned conditions:
  - Half-word with addr[0]=1.
  - Word with addr[1:0]≠0.
  - SIG_StoreSize=11.
  - Any of these goes IDLE→DONE with `err`=1 and no memory access.
- FSM states: IDLE, READ, WAIT, WRITE, DONE.
  - IDLE: on accept, byte/half-word → READ; word → WRITE; error → DONE.
  - READ (1 cycle): `mem_re`=1, `mem_addr` valid.
  - WAIT (MEM_LAT cycles, down-counter): `mem_rdata` is captured on the final WAIT edge.
  - WRITE (1 cycle): `mem_we`=1. `mem_wdata` is the merged word, or latched `wdata` for a word store.
  - DONE (1 cycle): `done`=1, then → IDLE.
- Latency in cycles after the accept edge, until `done` is high:
  - Byte/half-word: 3+MEM_LAT.
  - Word: 2.
  - Error: 1.
- `busy` rises in the cycle after accept and falls when returning to IDLE. A new `req` can be accepted on the edge ending DONE+1 (first IDLE cycle).
- `mem_re` and `mem_we` are never high in the same cycle. Each is high for exactly one cycle per access.
- `mem_addr` holds its value from READ through WRITE. Upper addr bits above ADDR_W+1 are ignored (wrap).

Test Plan:
1. Reset, then half-word store with mem word 0xAABBCCDD, addr=0x00000008, wdata=0x12343F3F, size=01. Required: `mem_re` in cycle 1, `mem_we` in cycle 3 with `mem_wdata`=0xAABB3F3F, `mem_addr`=2, `done` in cycle 4, `err`=0.
2. Same stimulus with addr=0x0000000A. Required: `mem_wdata`=0x3F3FCCDD.
3. Byte store with addr=0x00000007, wdata=0x000000FF, mem word 0x11223344. Required: `mem_wdata`=0xFF223344.
4. Word store with addr=0x00000004, wdata=0xFFFFFFFF. Required: `mem_re` never asserted, `mem_we` in cycle 1 with 0xFFFFFFFF, `done` in cycle 2.
5. Half-word store with addr=0x00000003; separately, size=11. Required: `done` and `err` both 1 in cycle 1, `mem_re`/`mem_we` stay 0, `busy` high for exactly 1 cycle.
6. Assert `reset` during WAIT of a half-word store. Required: all outputs 0 immediately, `mem_we` never pulses, FSM in IDLE. A following `req` with MEM_LAT=3 gives `done` in cycle 6.
